// File: rtl/sum_test_pkg.sv
// Shared types and default sizing for the sum-test thread-side initiator.
package sum_test_pkg;

   localparam int unsigned W_A_DEF     = 13;
   localparam int unsigned W_D_DEF     = 32;
   localparam int unsigned TIMEOUT_DEF = 4096;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FILL  = 3'd1,
      SEND  = 3'd2,
      WAIT  = 3'd3,
      CHECK = 3'd4
   } state_e;

endpackage

// File: rtl/sum_test_ctrl.sv
// Thread-side initiator: fills CoRAM with seed+i, sends the word count to the
// user logic, waits for the returned sum and checks it against a local tally.
module sum_test_ctrl
   import sum_test_pkg::*;
#(
   parameter int unsigned W_A     = W_A_DEF,
   parameter int unsigned W_D     = W_D_DEF,
   parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
   input  logic           CLK,
   input  logic           RST_N,
   input  logic           start,
   input  logic [W_A:0]   num_words,
   input  logic [W_D-1:0] seed,
   output logic [W_A-1:0] mem_addr,
   output logic [W_D-1:0] mem_d,
   output logic           mem_we,
   output logic [W_D-1:0] tx_d,
   output logic           tx_enq,
   input  logic           tx_full,
   input  logic [W_D-1:0] rx_q,
   output logic           rx_deq,
   input  logic           rx_empty,
   output logic           busy,
   output logic           done,
   output logic           pass,
   output logic           timeout,
   output logic [W_D-1:0] result,
   output logic [W_D-1:0] expected
);

   localparam int unsigned W_N = W_A + 1;
   localparam int unsigned W_T = $clog2(TIMEOUT + 1);
   localparam logic [W_N-1:0] N_MAX = {1'b1, {W_A{1'b0}}};

   state_e         state_q, state_d;
   logic [W_N-1:0] n_q, n_d;
   logic [W_A-1:0] i_q, i_d;
   logic [W_D-1:0] acc_q, acc_d;
   logic [W_T-1:0] tmo_q, tmo_d;
   logic           pass_q, pass_d;
   logic           timeout_q, timeout_d;
   logic [W_D-1:0] result_q, result_d;
   logic [W_D-1:0] expected_q, expected_d;
   logic           mem_we_q, mem_we_d;
   logic [W_A-1:0] mem_addr_q, mem_addr_d;
   logic [W_D-1:0] mem_d_q, mem_d_d;
   logic [W_D-1:0] tx_d_q, tx_d_d;
   logic           busy_q, busy_d;
   logic           done_q, done_d;
   logic [W_N-1:0] n_start;

   assign n_start = (num_words > N_MAX) ? N_MAX : num_words;

   // Registered outputs are loaded with the value they must show in the next
   // state; tx_enq/rx_deq stay combinational so they track the channel flags.
   always_comb begin
      state_d    = state_q;
      n_d        = n_q;
      i_d        = i_q;
      acc_d      = acc_q;
      tmo_d      = tmo_q;
      pass_d     = pass_q;
      timeout_d  = timeout_q;
      result_d   = result_q;
      expected_d = expected_q;
      mem_we_d   = 1'b0;
      mem_addr_d = mem_addr_q;
      mem_d_d    = mem_d_q;
      tx_d_d     = tx_d_q;
      done_d     = 1'b0;
      tx_enq     = 1'b0;
      rx_deq     = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               n_d        = n_start;
               i_d        = '0;
               acc_d      = '0;
               tmo_d      = '0;
               pass_d     = 1'b0;
               timeout_d  = 1'b0;
               tx_d_d     = W_D'(n_start);
               mem_addr_d = '0;
               mem_d_d    = seed;
               if (n_start != '0) begin
                  mem_we_d = 1'b1;
                  state_d  = FILL;
               end else begin
                  state_d  = SEND;
               end
            end
         end
         FILL: begin
            // mem_d_q already holds seed+i, so the pattern advances by one per write
            acc_d = acc_q + mem_d_q;
            if ({1'b0, i_q} == n_q - W_N'(1)) begin
               state_d = SEND;
            end else begin
               i_d        = i_q + W_A'(1);
               mem_we_d   = 1'b1;
               mem_addr_d = i_q + W_A'(1);
               mem_d_d    = mem_d_q + W_D'(1);
            end
         end
         SEND: begin
            if (!tx_full) begin
               tx_enq  = 1'b1;
               state_d = WAIT;
            end
         end
         WAIT: begin
            // A reply present in the final counted cycle takes priority over abort
            if (!rx_empty) begin
               rx_deq     = 1'b1;
               result_d   = rx_q;
               expected_d = acc_q;
               pass_d     = (rx_q == acc_q);
               done_d     = 1'b1;
               state_d    = CHECK;
            end else begin
               tmo_d = tmo_q + W_T'(1);
               if (tmo_d == W_T'(TIMEOUT)) begin
                  timeout_d = 1'b1;
                  pass_d    = 1'b0;
                  done_d    = 1'b1;
                  state_d   = IDLE;
               end
            end
         end
         CHECK: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q    <= IDLE;
         n_q        <= '0;
         i_q        <= '0;
         acc_q      <= '0;
         tmo_q      <= '0;
         pass_q     <= 1'b0;
         timeout_q  <= 1'b0;
         result_q   <= '0;
         expected_q <= '0;
         mem_we_q   <= 1'b0;
         mem_addr_q <= '0;
         mem_d_q    <= '0;
         tx_d_q     <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         n_q        <= n_d;
         i_q        <= i_d;
         acc_q      <= acc_d;
         tmo_q      <= tmo_d;
         pass_q     <= pass_d;
         timeout_q  <= timeout_d;
         result_q   <= result_d;
         expected_q <= expected_d;
         mem_we_q   <= mem_we_d;
         mem_addr_q <= mem_addr_d;
         mem_d_q    <= mem_d_d;
         tx_d_q     <= tx_d_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign mem_we   = mem_we_q;
   assign mem_addr = mem_addr_q;
   assign mem_d    = mem_d_q;
   assign tx_d     = tx_d_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign pass     = pass_q;
   assign timeout  = timeout_q;
   assign result   = result_q;
   assign expected = expected_q;

endmodule

// File: tb/tb_sum_test_ctrl.sv
// Directed bench for sum_test_ctrl: plays the memory and both channel FIFOs.
module tb_sum_test_ctrl;

   logic        CLK;
   logic        RST_N;
   logic        start;
   logic [13:0] num_words;
   logic [31:0] seed;
   logic [12:0] mem_addr;
   logic [31:0] mem_d;
   logic        mem_we;
   logic [31:0] tx_d;
   logic        tx_enq;
   logic        tx_full;
   logic [31:0] rx_q;
   logic        rx_deq;
   logic        rx_empty;
   logic        busy;
   logic        done;
   logic        pass;
   logic        timeout;
   logic [31:0] result;
   logic [31:0] expected;

   sum_test_ctrl #(.W_A(13), .W_D(32), .TIMEOUT(16)) dut (
      .CLK(CLK), .RST_N(RST_N), .start(start), .num_words(num_words), .seed(seed),
      .mem_addr(mem_addr), .mem_d(mem_d), .mem_we(mem_we),
      .tx_d(tx_d), .tx_enq(tx_enq), .tx_full(tx_full),
      .rx_q(rx_q), .rx_deq(rx_deq), .rx_empty(rx_empty),
      .busy(busy), .done(done), .pass(pass), .timeout(timeout),
      .result(result), .expected(expected)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int n_tests = 0;
   int n_fail  = 0;

   // observations from the most recent run
   int          wr_cnt, enq_cnt, deq_cnt, enq_c, done_c, full_enq;
   int          wr_first_c, wr_last_c;
   bit          wr_gap, busy_c1;
   logic [31:0] enq_data;
   logic [31:0] wr_addr_q[$];
   logic [31:0] wr_data_q[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic wait_idle();
      for (int k = 0; k < 20; k++) begin
         @(negedge CLK);
         #1;
         if (!busy) break;
      end
      if (busy) check("idle_wait", 32'(busy), 32'd0);
   endtask

   // One transaction; c counts cycles after the edge that samples start.
   task automatic run(input logic [13:0] nw, input logic [31:0] sd, input int full_cyc,
                      input bit reply_en, input int dly, input logic [31:0] reply,
                      input int budget);
      int c = 0;
      int full_seen = 0;
      bit pop_pending = 0;
      bit replied = 0;
      wr_cnt = 0; enq_cnt = 0; deq_cnt = 0; enq_c = -1; done_c = -1; full_enq = 0;
      wr_first_c = -1; wr_last_c = -1; wr_gap = 0; busy_c1 = 0; enq_data = '0;
      wr_addr_q.delete();
      wr_data_q.delete();
      wait_idle();
      tx_full   = (full_cyc > 0);
      rx_empty  = 1'b1;
      rx_q      = '0;
      start     = 1'b1;
      num_words = nw;
      seed      = sd;
      while (c < budget && done_c < 0) begin
         @(negedge CLK);
         c++;
         start = 1'b0;
         if (pop_pending) begin
            rx_empty    = 1'b1;
            pop_pending = 0;
         end
         if (tx_full && enq_c < 0 && full_seen >= full_cyc) tx_full = 1'b0;
         if (reply_en && !replied && enq_c >= 0 && c == enq_c + 1 + dly) begin
            rx_q     = reply;
            rx_empty = 1'b0;
            replied  = 1;
         end
         #1;
         if (c == 1) busy_c1 = busy;
         if (mem_we) begin
            if (wr_cnt == 0) wr_first_c = c;
            else if (c != wr_last_c + 1) wr_gap = 1;
            wr_last_c = c;
            wr_addr_q.push_back(32'(mem_addr));
            wr_data_q.push_back(mem_d);
            wr_cnt++;
         end
         if (busy && !mem_we && enq_c < 0 && tx_full) full_seen++;
         if (tx_enq) begin
            if (tx_full) full_enq++;
            enq_cnt++;
            enq_data = tx_d;
            if (enq_c < 0) enq_c = c;
         end
         if (rx_deq) begin
            deq_cnt++;
            pop_pending = 1;
         end
         if (done) done_c = c;
      end
      if (done_c < 0) check("done_seen", 32'd0, 32'd1);
      tx_full  = 1'b0;
      rx_empty = 1'b1;
   endtask

   initial begin
      RST_N = 1'b1; start = 1'b0; num_words = '0; seed = '0;
      tx_full = 1'b0; rx_q = '0; rx_empty = 1'b1;
      #3 RST_N = 1'b0;
      repeat (2) @(negedge CLK);
      #1;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_mem_we", 32'(mem_we), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_pass", 32'(pass), 32'd0);
      check("rst_result", result, 32'd0);
      check("rst_tx_enq", 32'(tx_enq), 32'd0);
      @(negedge CLK);
      RST_N = 1'b1;

      // N=4 seed=1, correct reply
      run(14'd4, 32'd1, 0, 1, 0, 32'd10, 100);
      check("t1_wr_cnt", 32'(wr_cnt), 32'd4);
      check("t1_wr_first", 32'(wr_first_c), 32'd1);
      check("t1_wr_gap", 32'(wr_gap), 32'd0);
      for (int k = 0; k < 4; k++) begin
         check("t1_addr", wr_addr_q[k], 32'(k));
         check("t1_data", wr_data_q[k], 32'(k + 1));
      end
      check("t1_busy", 32'(busy_c1), 32'd1);
      check("t1_enq_cnt", 32'(enq_cnt), 32'd1);
      check("t1_tx_d", enq_data, 32'd4);
      check("t1_deq_cnt", 32'(deq_cnt), 32'd1);
      check("t1_latency", 32'(done_c), 32'd7);
      check("t1_result", result, 32'd10);
      check("t1_expected", expected, 32'd10);
      check("t1_pass", 32'(pass), 32'd1);
      check("t1_timeout", 32'(timeout), 32'd0);
      @(negedge CLK);
      #1;
      check("t1_done_pulse", 32'(done), 32'd0);
      check("t1_idle", 32'(busy), 32'd0);

      // wrong reply
      run(14'd4, 32'd1, 0, 1, 0, 32'd11, 100);
      check("t2_pass", 32'(pass), 32'd0);
      check("t2_timeout", 32'(timeout), 32'd0);
      check("t2_result", result, 32'd11);
      check("t2_expected", expected, 32'd10);

      // tx_full backpressure for five SEND cycles; 100+101+102=303
      run(14'd3, 32'd100, 5, 1, 0, 32'd303, 100);
      check("t3_enq_while_full", 32'(full_enq), 32'd0);
      check("t3_enq_cnt", 32'(enq_cnt), 32'd1);
      check("t3_enq_cycle", 32'(enq_c), 32'd9);
      check("t3_tx_d", enq_data, 32'd3);
      check("t3_pass", 32'(pass), 32'd1);

      // N=0
      run(14'd0, 32'd7, 0, 1, 0, 32'd0, 100);
      check("t4_wr_cnt", 32'(wr_cnt), 32'd0);
      check("t4_tx_d", enq_data, 32'd0);
      check("t4_enq_cycle", 32'(enq_c), 32'd1);
      check("t4_latency", 32'(done_c), 32'd3);
      check("t4_expected", expected, 32'd0);
      check("t4_pass", 32'(pass), 32'd1);

      // no reply: sixteen empty WAIT cycles, done on the cycle after
      run(14'd1, 32'd3, 0, 0, 0, 32'd0, 100);
      check("t5_wait_len", 32'(done_c - enq_c), 32'd17);
      check("t5_timeout", 32'(timeout), 32'd1);
      check("t5_pass", 32'(pass), 32'd0);
      check("t5_deq_cnt", 32'(deq_cnt), 32'd0);

      // reply lands in the sixteenth WAIT cycle: data beats the abort
      run(14'd1, 32'd3, 0, 1, 15, 32'd3, 100);
      check("t6_timeout", 32'(timeout), 32'd0);
      check("t6_deq_cnt", 32'(deq_cnt), 32'd1);
      check("t6_pass", 32'(pass), 32'd1);

      // oversize request clamps to 8192 words; sum 0..8191 = 33550336
      run(14'h2005, 32'd0, 0, 1, 0, 32'd33550336, 8500);
      check("t7_wr_cnt", 32'(wr_cnt), 32'd8192);
      check("t7_wr_gap", 32'(wr_gap), 32'd0);
      check("t7_last_addr", wr_addr_q[8191], 32'd8191);
      check("t7_tx_d", enq_data, 32'd8192);
      check("t7_expected", expected, 32'd33550336);
      check("t7_pass", 32'(pass), 32'd1);

      // asynchronous reset during FILL at i=2
      wait_idle();
      start = 1'b1; num_words = 14'd8; seed = 32'd5;
      for (int k = 0; k < 20; k++) begin
         @(negedge CLK);
         start = 1'b0;
         #1;
         if (mem_we && mem_addr == 13'd2) break;
      end
      check("t8_reached_i2", 32'(mem_addr), 32'd2);
      #2 RST_N = 1'b0;
      #1;
      check("t8_mem_we", 32'(mem_we), 32'd0);
      check("t8_mem_addr", 32'(mem_addr), 32'd0);
      check("t8_mem_d", mem_d, 32'd0);
      check("t8_busy", 32'(busy), 32'd0);
      check("t8_tx_d", tx_d, 32'd0);
      check("t8_tx_enq", 32'(tx_enq), 32'd0);
      check("t8_rx_deq", 32'(rx_deq), 32'd0);
      check("t8_pass", 32'(pass), 32'd0);
      check("t8_result", result, 32'd0);
      check("t8_expected", expected, 32'd0);
      @(negedge CLK);
      RST_N = 1'b1;

      run(14'd2, 32'hFFFF_FFFF, 0, 1, 0, 32'hFFFF_FFFF, 100);
      check("t9_wr_cnt", 32'(wr_cnt), 32'd2);
      check("t9_data0", wr_data_q[0], 32'hFFFF_FFFF);
      check("t9_data1", wr_data_q[1], 32'h0000_0000);
      check("t9_expected", expected, 32'hFFFF_FFFF);
      check("t9_pass", 32'(pass), 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/sum_test_ctrl.md
Name: sum_test_ctrl

Overview:
- Thread-side initiator for the sum-test user logic.
- Fills the shared CoRAM data memory with a deterministic pattern through the memory's write port.
- Sends the word count to the user logic over the thread-to-user channel, then waits for the sum returned on the user-to-thread channel.
- Checks the returned sum against a locally accumulated expected value. Used as a hardware stand-in for the control thread in simulation and FPGA self-test.

Parameters:
- W_A, 13, memory address width.
- W_D, 32, data and channel word width.
- TIMEOUT, 4096, cycles allowed in WAIT before abort.

Ports:
- CLK  in  1  clock; all logic rising-edge.
- RST_N  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- num_words  in  W_A+1  words to fill and sum, 0..2^W_A.
- seed  in  W_D  first pattern word.
- mem_addr  out  W_A  memory write address.
- mem_d  out  W_D  memory write data.
- mem_we  out  1  memory write enable.
- tx_d  out  W_D  channel word to the user logic.
- tx_enq  out  1  enqueue strobe.
- tx_full  in  1  thread-to-user channel full.
- rx_q  in  W_D  head word of the user-to-thread channel; valid while rx_empty=0 (first-word-fall-through).
- rx_deq  out  1  dequeue strobe.
- rx_empty  in  1  user-to-thread channel empty.
- busy  out  1  high outside IDLE.
- done  out  1  one-cycle completion pulse.
- pass  out  1  last-run verdict.
- timeout  out  1  last run aborted by timeout.
- result  out  W_D  last sum received.
- expected  out  W_D  last expected sum.

Behaviour:
- Reset (RST_N low, asynchronous): state=IDLE. All outputs 0: mem_*, tx_*, rx_deq, busy, done, pass, timeout, result, expected. Internal counters cleared.
- Reset mid-operation: run abandoned immediately. No partial enqueue or dequeue survives.
- Any num_words above 2^W_A is clamped to 2^W_A.

State machine:
- IDLE
  - On start=1: latch N=num_words and seed; clear the accumulator, index i and timeout counter; clear pass/timeout.
  - Next state is FILL if N>0, else SEND.
  - start while busy is ignored.
- FILL
  - One write per cycle: mem_we=1, mem_addr=i[W_A-1:0], mem_d=seed+i (mod 2^W_D).
  - Accumulator += mem_d (mod 2^W_D).
  - Last write when i=N-1, then SEND. Fill of N words takes exactly N cycles.
  - i counts up to 2^W_A-1 only; no address wrap occurs.
- SEND
  - tx_d=N zero-extended to W_D; tx_enq=1 only when tx_full=0.
  - Exactly one enqueue per run. While tx_full=1, tx_enq=0 and the state holds.
  - After the enqueue cycle, go to WAIT.
- WAIT
  - Timeout counter increments each cycle that rx_empty=1.
  - When rx_empty=0: rx_deq=1 for one cycle, result<=rx_q, go to CHECK.
  - If the counter reaches TIMEOUT first: timeout<=1, pass<=0, done=1, go to IDLE. No dequeue occurs.
  - If rx_empty falls in the same cycle the counter reaches TIMEOUT, the data wins.
- CHECK (1 cycle)
  - expected<=accumulator; pass<=(result==accumulator); done=1; go to IDLE.
- pass, timeout, result and expected hold until the next accepted start.
- Expected sum with N=0 is 0.
- Latency (no backpressure, instant reply): done asserts N+3 cycles after start, plus channel reply delay.

Decomposition:
- Package sum_test_pkg:
  - state enum IDLE/FILL/SEND/WAIT/CHECK;
  - default widths W_A/W_D;
  - TIMEOUT default.
- No sub-module required. The timeout counter and pattern generator are inline.

Test Plan:
- N=4, seed=1: writes at addresses 0..3 with data 1,2,3,4 on consecutive cycles; tx_d=4 enqueued once; bench replies 10 → result=10, expected=10, pass=1, done pulse.
- N=4, seed=1, bench replies 11 → pass=0, timeout=0, result=11, expected=10.
- tx_full held high 5 cycles entering SEND → tx_enq stays 0, then exactly one enqueue of tx_d=N when tx_full drops.
- N=0 → no mem_we; tx_d=0 enqueued; reply 0 → pass=1.
- No reply, TIMEOUT=16 → done 16 cycles into WAIT; timeout=1, pass=0, rx_deq never asserted.
- RST_N low during FILL at i=2 → all outputs 0 asynchronously; after release, IDLE; a new start with seed=0xFFFFFFFF, N=2 writes 0xFFFFFFFF then 0x00000000, and expected=0xFFFFFFFF.
